// File: rtl/debounce_entry.sv
// rtl/debounce_entry.sv - four-button debounced digit entry front end for a combination lock
// Optional feature: define AUTO_REPEAT_EN to enable hold-to-repeat on the increment/decrement buttons.
module debounce_entry #(
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int MAX_DIGIT      = 9,
    parameter int REPEAT_DELAY   = 12500000,
    parameter int REPEAT_PERIOD  = 2500000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Switch_1,
    input  logic       i_Switch_2,
    input  logic       i_Switch_3,
    input  logic       i_Switch_4,
    output logic [3:0] o_Binary_Num,
    output logic       o_Enter,
    output logic       o_Clear,
    output logic [3:0] o_Debounced
);

    localparam logic [23:0] DEB_LAST  = 24'(DEBOUNCE_LIMIT - 1);
    localparam logic [3:0]  DIGIT_MAX = 4'(MAX_DIGIT);

    // Bit order everywhere: 0 = increment, 1 = decrement, 2 = enter, 3 = clear.
    logic [3:0]       raw_sw;
    logic [3:0]       sync1_q;
    logic [3:0]       sync2_q;
    logic [3:0]       deb_q;
    logic [3:0]       deb_d;
    logic [3:0][23:0] cnt_q;
    logic [3:0][23:0] cnt_d;
    logic [3:0]       toggle;
    logic [3:0]       press;
    logic [3:0]       num_q;
    logic [3:0]       num_d;
    logic             enter_q;
    logic             enter_d;
    logic             clear_q;
    logic             clear_d;
    logic             rep_up;
    logic             rep_dn;
    logic             step_up;
    logic             step_dn;

    assign raw_sw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

    // Two-flop synchronizer on every raw button before anything else looks at it.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_sw;
            sync2_q <= sync1_q;
        end
    end

    // Per-button stability counter: any matching cycle restarts it, the last count flips the level.
    always_comb begin
        deb_d  = deb_q;
        cnt_d  = cnt_q;
        toggle = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DEB_LAST) begin
                deb_d[i]  = ~deb_q[i];
                cnt_d[i]  = '0;
                toggle[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + 24'd1;
            end
        end
    end

    // A press is the cycle whose debounced level is about to rise; releases are ignored.
    assign press = toggle & ~deb_q;

`ifdef AUTO_REPEAT_EN
    localparam logic [23:0] DELAY_LAST  = 24'(REPEAT_DELAY - 1);
    localparam logic [23:0] PERIOD_LAST = 24'(REPEAT_PERIOD - 1);

    logic [23:0] rep_cnt_q;
    logic [23:0] rep_cnt_d;
    logic        rep_armed_q;
    logic        rep_armed_d;
    logic        rep_fire;
    logic        hold_alone;
    logic        rep_restart;

    // Repeat runs only while exactly one of increment/decrement is held with no fresh press.
    assign hold_alone  = deb_q[0] ^ deb_q[1];
    assign rep_restart = ~hold_alone | press[3] | press[1] | press[0];

    // First step waits the long delay, later steps the short period (rep_armed_q selects).
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_armed_d = rep_armed_q;
        rep_fire    = 1'b0;
        if (rep_restart) begin
            rep_cnt_d   = '0;
            rep_armed_d = 1'b0;
        end else if (rep_cnt_q == (rep_armed_q ? PERIOD_LAST : DELAY_LAST)) begin
            rep_fire    = 1'b1;
            rep_cnt_d   = '0;
            rep_armed_d = 1'b1;
        end else begin
            rep_cnt_d = rep_cnt_q + 24'd1;
        end
    end

    // Repeat timing registers.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
        end
    end

    assign rep_up = rep_fire & deb_q[0];
    assign rep_dn = rep_fire & deb_q[1];
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
    assign rep_up = 1'b0;
    assign rep_dn = 1'b0;
`endif

    assign step_up = press[0] | rep_up;
    assign step_dn = press[1] | rep_dn;

    // Clear beats everything; an enter press holds the digit steady so the lock captures a stable value.
    always_comb begin
        num_d   = num_q;
        enter_d = 1'b0;
        clear_d = 1'b0;
        if (press[3]) begin
            num_d   = '0;
            clear_d = 1'b1;
        end else if (press[2]) begin
            enter_d = 1'b1;
        end else if (step_up && !step_dn) begin
            num_d = (num_q == DIGIT_MAX) ? 4'd0 : num_q + 4'd1;
        end else if (step_dn && !step_up) begin
            num_d = (num_q == 4'd0) ? DIGIT_MAX : num_q - 4'd1;
        end
    end

    // Debounce state, composed digit and output pulses.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            deb_q   <= '0;
            cnt_q   <= '0;
            num_q   <= '0;
            enter_q <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            enter_q <= enter_d;
            clear_q <= clear_d;
        end
    end

    assign o_Binary_Num = num_q;
    assign o_Enter      = enter_q;
    assign o_Clear      = clear_q;
    assign o_Debounced  = deb_q;

endmodule

// File: tb/tb_debounce_entry.sv
// tb/tb_debounce_entry.sv - self-checking bench for debounce_entry with a window-based reference model
module tb_debounce_entry;

    localparam int DL = 8;
    localparam int MD = 9;
    localparam int RD = 40;
    localparam int RP = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sw = 4'd0;
    logic [3:0] o_Binary_Num;
    logic       o_Enter;
    logic       o_Clear;
    logic [3:0] o_Debounced;

    int checks = 0;
    int failures = 0;

    // Reference model: raw-level history window, debounced levels, digit, pulses, hold age.
    logic [3:0] h [0:DL+1];
    logic [3:0] m_deb;
    int         m_num;
    bit         m_enter;
    bit         m_clear;
    int         m_age;
    int         hold_left [4];

    always #5 clk = ~clk;

    debounce_entry #(
        .DEBOUNCE_LIMIT(DL),
        .MAX_DIGIT(MD),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .i_Clk(clk),
        .i_Rst_L(rst_n),
        .i_Switch_1(sw[0]),
        .i_Switch_2(sw[1]),
        .i_Switch_3(sw[2]),
        .i_Switch_4(sw[3]),
        .o_Binary_Num(o_Binary_Num),
        .o_Enter(o_Enter),
        .o_Clear(o_Clear),
        .o_Debounced(o_Debounced)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k <= DL + 1; k++) h[k] = 4'd0;
        m_deb   = 4'd0;
        m_num   = 0;
        m_enter = 1'b0;
        m_clear = 1'b0;
        m_age   = 0;
    endtask

    // A level is accepted once the last DL synchronized samples (raw delayed two edges) all disagree with it.
    task automatic model_edge();
        logic [3:0] tog;
        logic [3:0] prs;
        bit         fire;
        bit         up;
        bit         dn;
        bit         all_diff;
        if (!rst_n) begin
            model_clear();
            return;
        end
        for (int k = DL + 1; k > 0; k--) h[k] = h[k-1];
        h[0] = sw;
        tog = 4'd0;
        for (int i = 0; i < 4; i++) begin
            all_diff = 1'b1;
            for (int k = 2; k <= DL + 1; k++)
                if (h[k][i] == m_deb[i]) all_diff = 1'b0;
            tog[i] = all_diff;
        end
        prs  = tog & ~m_deb;
        fire = 1'b0;
`ifdef AUTO_REPEAT_EN
        if (!(m_deb[0] ^ m_deb[1]) || prs[3] || prs[1] || prs[0]) begin
            m_age = 0;
        end else begin
            m_age++;
            if (m_age == RD || (m_age > RD && ((m_age - RD) % RP) == 0)) fire = 1'b1;
        end
`endif
        up = prs[0] | (fire & m_deb[0]);
        dn = prs[1] | (fire & m_deb[1]);
        m_enter = 1'b0;
        m_clear = 1'b0;
        if (prs[3]) begin
            m_num   = 0;
            m_clear = 1'b1;
        end else if (prs[2]) begin
            m_enter = 1'b1;
        end else if (up && !dn) begin
            m_num = (m_num == MD) ? 0 : m_num + 1;
        end else if (dn && !up) begin
            m_num = (m_num == 0) ? MD : m_num - 1;
        end
        m_deb = m_deb ^ tog;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_val("m_deb", o_Debounced, m_deb);
        check_val("m_num", o_Binary_Num, m_num);
        check_val("m_enter", o_Enter, m_enter);
        check_val("m_clear", o_Clear, m_clear);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic press_sw(input int idx);
        sw[idx] = 1'b1;
        repeat (DL + 4) tick();
        sw[idx] = 1'b0;
        repeat (DL + 4) tick();
    endtask

    initial begin
        int lat;
        int ecount;
        int ccount;
        model_clear();
        sw    = 4'd0;
        rst_n = 1'b0;
        repeat (2) tick();
        check_val("rst_num", o_Binary_Num, 0);
        check_val("rst_deb", o_Debounced, 0);
        check_val("rst_enter", o_Enter, 0);
        check_val("rst_clear", o_Clear, 0);
        rst_n = 1'b1;

        // Bouncing increment: 3 high / 2 low for 20 cycles, then held.
        for (int c = 0; c < 20; c++) begin
            sw[0] = ((c % 5) < 3);
            tick();
        end
        sw[0] = 1'b1;
        lat = 0;
        while (o_Binary_Num == 4'd0 && lat < 40) begin
            tick();
            lat++;
        end
        check_val("bounce_lat", lat, DL + 2);
        check_val("bounce_num", o_Binary_Num, 1);
        repeat (20) tick();
        check_val("bounce_single", o_Binary_Num, 1);
        sw[0] = 1'b0;
        repeat (DL + 4) tick();

        // Ten increments wrap 9 -> 0, one decrement wraps 0 -> 9.
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            press_sw(0);
            check_val("inc_seq", o_Binary_Num, (i + 1) % (MD + 1));
        end
        press_sw(1);
        check_val("dec_wrap", o_Binary_Num, MD);

        // Enter held 100 cycles at digit 5.
        pulse_reset();
        repeat (5) press_sw(0);
        check_val("pre_enter_num", o_Binary_Num, 5);
        sw[2] = 1'b1;
        ecount = 0;
        repeat (100) begin
            tick();
            if (o_Enter) ecount++;
        end
        sw[2] = 1'b0;
        repeat (DL + 4) begin
            tick();
            if (o_Enter) ecount++;
        end
        check_val("enter_pulses", ecount, 1);
        check_val("enter_num", o_Binary_Num, 5);

        // Enter and clear together at digit 7.
        repeat (2) press_sw(0);
        check_val("pre_clear_num", o_Binary_Num, 7);
        sw[2] = 1'b1;
        sw[3] = 1'b1;
        ecount = 0;
        ccount = 0;
        repeat (40) begin
            tick();
            if (o_Enter) ecount++;
            if (o_Clear) ccount++;
        end
        sw[2] = 1'b0;
        sw[3] = 1'b0;
        repeat (DL + 4) begin
            tick();
            if (o_Enter) ecount++;
            if (o_Clear) ccount++;
        end
        check_val("clr_pulses", ccount, 1);
        check_val("clr_enter", ecount, 0);
        check_val("clr_num", o_Binary_Num, 0);

        // Reset mid-debounce with the increment button still held.
        repeat (3) press_sw(0);
        check_val("pre_rst_num", o_Binary_Num, 3);
        sw[0] = 1'b1;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check_val("async_rst_num", o_Binary_Num, 0);
        check_val("async_rst_deb", o_Debounced, 0);
        check_val("async_rst_enter", o_Enter, 0);
        check_val("async_rst_clear", o_Clear, 0);
        tick();
        rst_n = 1'b1;
        lat = 0;
        while (o_Binary_Num == 4'd0 && lat < 40) begin
            tick();
            lat++;
        end
        check_val("post_rst_lat", lat, DL + 2);
        check_val("post_rst_num", o_Binary_Num, 1);

        // Continued hold of increment after its press.
`ifdef AUTO_REPEAT_EN
        repeat (RD - 1) tick();
        check_val("rep_before", o_Binary_Num, 1);
        tick();
        check_val("rep_first", o_Binary_Num, 2);
        repeat (RP) tick();
        check_val("rep_second", o_Binary_Num, 3);
        repeat (RP) tick();
        check_val("rep_third", o_Binary_Num, 4);
        repeat (RP) tick();
        check_val("rep_fourth", o_Binary_Num, 5);
`else
        repeat (70) tick();
        check_val("hold_no_repeat", o_Binary_Num, 1);
`endif
        sw[0] = 1'b0;
        repeat (DL + 4) tick();

        // Randomized button activity against the model, with occasional resets.
        pulse_reset();
        for (int i = 0; i < 4; i++) hold_left[i] = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (hold_left[i] == 0) begin
                    if ($urandom_range(0, 1) == 1) sw[i] = ~sw[i];
                    if ($urandom_range(0, 3) == 0)
                        hold_left[i] = $urandom_range(1, (i < 2) ? 120 : 40);
                    else
                        hold_left[i] = $urandom_range(1, 12);
                end else begin
                    hold_left[i]--;
                end
            end
            if ($urandom_range(0, 999) == 0) pulse_reset();
            else tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/debounce_entry.md
DEBOUNCE_ENTRY -- requirements
Module: debounce_entry

Interface
REQ-001 The parameter DEBOUNCE_LIMIT SHALL default to 250000 and set the consecutive stable cycles required to accept a switch change (10 ms at 25 MHz); legal range 2 to 2^24-1.
REQ-002 The parameter MAX_DIGIT SHALL default to 9 and set the largest digit value; legal range 1 to 15.
REQ-003 The parameter REPEAT_DELAY SHALL default to 12500000 and set the hold cycles before auto-repeat starts.
REQ-004 The parameter REPEAT_PERIOD SHALL default to 2500000 and set the cycles between auto-repeat steps.
REQ-005 i_Clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-006 i_Rst_L  input  1  SHALL be the asynchronous, active-low reset.
REQ-007 i_Switch_1  input  1  SHALL be the raw, asynchronous increment button (active high).
REQ-008 i_Switch_2  input  1  SHALL be the raw, asynchronous decrement button (active high).
REQ-009 i_Switch_3  input  1  SHALL be the raw, asynchronous enter button (active high).
REQ-010 i_Switch_4  input  1  SHALL be the raw, asynchronous clear button (active high).
REQ-011 o_Binary_Num  output  4  SHALL be the registered digit currently composed, fed to the lock's digit input.
REQ-012 o_Enter  output  1  SHALL be a one-cycle pulse, fed to the lock's enter input, marking o_Binary_Num as valid for capture.
REQ-013 o_Clear  output  1  SHALL be a one-cycle pulse issued on an accepted clear press.
REQ-014 o_Debounced  output  4  SHALL be the debounced levels of switches 4..1 (bit 0 = switch 1).

Function
REQ-015 Each raw switch SHALL pass through a two-flop synchronizer before any other logic.
REQ-016 Each switch SHALL have an independent debounce counter that clears whenever the synchronized level equals the debounced level and increments otherwise.
REQ-017 The debounced level SHALL toggle, and the counter clear, on the cycle the counter reaches DEBOUNCE_LIMIT-1; one mismatch-free cycle restarts the count.
REQ-018 Latency from a clean raw edge to the debounced edge SHALL be exactly 2+DEBOUNCE_LIMIT cycles.
REQ-019 A press event SHALL be the cycle on which a debounced level goes 0 to 1; release events produce no action.
REQ-020 Increment press: o_Binary_Num SHALL become value+1, wrapping from MAX_DIGIT to 0.
REQ-021 Decrement press: o_Binary_Num SHALL become value-1, wrapping from 0 to MAX_DIGIT.
REQ-022 Simultaneous increment and decrement presses SHALL leave o_Binary_Num unchanged.
REQ-023 Enter press SHALL drive o_Enter high for exactly one cycle, the cycle after the event, with o_Binary_Num stable across that cycle and the one before it.
REQ-024 Enter press SHALL NOT alter o_Binary_Num.
REQ-025 Clear press SHALL set o_Binary_Num to 0 and pulse o_Clear for one cycle; it overrides increment, decrement and enter in the same cycle, and o_Enter SHALL stay low.
REQ-026 Holding enter or clear SHALL never produce a second pulse before release and re-press.

Reset
REQ-027 Asserting i_Rst_L low SHALL immediately clear synchronizers, debounce counters, repeat counters, o_Debounced, o_Binary_Num, o_Enter and o_Clear to 0, including mid-debounce and mid-pulse.
REQ-028 After deassertion, a switch already held high SHALL register as a press once debounce completes (2+DEBOUNCE_LIMIT cycles).

Configuration
REQ-029 With AUTO_REPEAT_EN defined, holding increment or decrement alone SHALL repeat the step REPEAT_DELAY cycles after the press and every REPEAT_PERIOD cycles thereafter until release, honouring wrap rules.
REQ-030 With AUTO_REPEAT_EN defined, holding both increment and decrement, or any clear press, SHALL halt and reset repeat timing.
REQ-031 Without AUTO_REPEAT_EN, repeat counters SHALL not exist and each press SHALL give exactly one step; REPEAT_DELAY and REPEAT_PERIOD are ignored.

Verification (DEBOUNCE_LIMIT=8, MAX_DIGIT=9, REPEAT_DELAY=40, REPEAT_PERIOD=10)
REQ-032 Switch 1 bounces 3 cycles high/2 low for 20 cycles then holds high -> exactly one step, o_Binary_Num 0->1, 10 cycles after final rising edge.
REQ-033 Ten increment presses from 0 -> sequence 1..9 then 0; one decrement from 0 -> 9.
REQ-034 o_Binary_Num=5, enter held 100 cycles -> single o_Enter pulse, o_Binary_Num stays 5.
REQ-035 Enter and clear raised in same cycle with o_Binary_Num=7 -> o_Clear one pulse, o_Enter stays 0, o_Binary_Num=0.
REQ-036 i_Rst_L pulsed low 1 cycle mid-debounce of switch 1 -> all outputs 0 immediately; switch still high -> step to 1 exactly 10 cycles after release.
REQ-037 AUTO_REPEAT_EN defined, increment held 70 cycles after debounce -> values 1 (press), 2 (+40), 3 (+50), 4 (+60), 5 (+70).
